// File: rtl/fastoutput_pkg.sv
// rtl/fastoutput_pkg.sv - shared types and defaults for the fast pulse-train generator
package fastoutput_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int WID_W_DEF = 16;
  localparam int NCH       = 4;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/fastoutput_channel.sv
// rtl/fastoutput_channel.sv - one pulse-train channel: FSM, phase/remaining counters, edge counter
module fastoutput_channel
  import fastoutput_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WID_W = WID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] count,
  input  logic [WID_W-1:0] high,
  input  logic [WID_W-1:0] low,
  output logic             fast,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edges
);

  state_t           state;
  logic [WID_W-1:0] phase;
  logic [WID_W-1:0] high_m1;
  logic [WID_W-1:0] low_m1;
  logic [CNT_W-1:0] remaining;
  logic [WID_W-1:0] high_in_m1;
  logic [WID_W-1:0] low_in_m1;

  // A zero width is stretched to one cycle, so the phase reload value saturates at 0.
  assign high_in_m1 = (high == '0) ? '0 : high - 1'b1;
  assign low_in_m1  = (low == '0) ? '0 : low - 1'b1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fast      <= 1'b0;
      done      <= 1'b0;
      edges     <= '0;
      phase     <= '0;
      high_m1   <= '0;
      low_m1    <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              state     <= HIGH;
              fast      <= 1'b1;
              edges     <= edges + 1'b1;
              phase     <= high_in_m1;
              high_m1   <= high_in_m1;
              low_m1    <= low_in_m1;
              remaining <= count;
            end
          end
        end
        HIGH: begin
          if (stop) begin
            state <= IDLE;
            fast  <= 1'b0;
          end else if (phase == '0) begin
            state <= LOW;
            fast  <= 1'b0;
            phase <= low_m1;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        LOW: begin
          if (stop) begin
            state <= IDLE;
            fast  <= 1'b0;
          end else if (phase == '0) begin
            if (remaining > CNT_W'(1)) begin
              remaining <= remaining - 1'b1;
              state     <= HIGH;
              fast      <= 1'b1;
              edges     <= edges + 1'b1;
              phase     <= high_m1;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          fast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fastoutput_gen.sv
// rtl/fastoutput_gen.sv - 4-channel fast pulse-train generator with shared command port
module fastoutput_gen
  import fastoutput_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WID_W = WID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_chan,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WID_W-1:0] cmd_high,
  input  logic [WID_W-1:0] cmd_low,
  input  logic [3:0]       stop,
  output logic [3:0]       Fast,
  output logic [3:0]       busy,
  output logic [3:0]       done,
  output logic [CNT_W-1:0] channel0,
  output logic [CNT_W-1:0] channel1,
  output logic [CNT_W-1:0] channel2,
  output logic [CNT_W-1:0] channel3
);

  logic [CNT_W-1:0] edges [NCH];
  logic             accept;

  // Stop on the addressed channel blocks acceptance even while that channel is idle.
  assign cmd_ready = !busy[cmd_chan] && !stop[cmd_chan];
  assign accept    = cmd_valid && cmd_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    fastoutput_channel #(
      .CNT_W(CNT_W),
      .WID_W(WID_W)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .start(accept && (cmd_chan == 2'(i))),
      .stop (stop[i]),
      .count(cmd_count),
      .high (cmd_high),
      .low  (cmd_low),
      .fast (Fast[i]),
      .busy (busy[i]),
      .done (done[i]),
      .edges(edges[i])
    );
  end

  assign channel0 = edges[0];
  assign channel1 = edges[1];
  assign channel2 = edges[2];
  assign channel3 = edges[3];

endmodule

// File: tb/tb_fastoutput_gen.sv
// tb/tb_fastoutput_gen.sv - directed self-checking bench for fastoutput_gen
module tb_fastoutput_gen;

  localparam int CW  = 32;
  localparam int WW  = 16;
  localparam int SCW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_chan;
  logic [CW-1:0] cmd_count;
  logic [WW-1:0] cmd_high;
  logic [WW-1:0] cmd_low;
  logic [3:0]    stop;
  logic [3:0]    fast;
  logic [3:0]    busy;
  logic [3:0]    done;
  logic [CW-1:0] channel0, channel1, channel2, channel3;

  logic           w_cmd_valid;
  logic           w_cmd_ready;
  logic [1:0]     w_cmd_chan;
  logic [SCW-1:0] w_cmd_count;
  logic [WW-1:0]  w_cmd_high;
  logic [WW-1:0]  w_cmd_low;
  logic [3:0]     w_stop;
  logic [3:0]     w_fast;
  logic [3:0]     w_busy;
  logic [3:0]     w_done;
  logic [SCW-1:0] w_ch0, w_ch1, w_ch2, w_ch3;

  int passed = 0;
  int total  = 0;

  logic [CW-1:0] mc [4];
  logic [3:0]    prev_fast;
  int            ndone;

  fastoutput_gen dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_count(cmd_count), .cmd_high(cmd_high), .cmd_low(cmd_low),
    .stop(stop), .Fast(fast), .busy(busy), .done(done),
    .channel0(channel0), .channel1(channel1), .channel2(channel2), .channel3(channel3)
  );

  fastoutput_gen #(.CNT_W(SCW), .WID_W(WW)) dut_w (
    .clk(clk), .rst(rst), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_chan(w_cmd_chan), .cmd_count(w_cmd_count), .cmd_high(w_cmd_high), .cmd_low(w_cmd_low),
    .stop(w_stop), .Fast(w_fast), .busy(w_busy), .done(w_done),
    .channel0(w_ch0), .channel1(w_ch1), .channel2(w_ch2), .channel3(w_ch3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] chan_val(input int i);
    case (i)
      0:       return channel0;
      1:       return channel1;
      2:       return channel2;
      default: return channel3;
    endcase
  endfunction

  task automatic issue(input logic [1:0] ch, input logic [CW-1:0] n,
                       input logic [WW-1:0] h, input logic [WW-1:0] l);
    cmd_chan  = ch;
    cmd_count = n;
    cmd_high  = h;
    cmd_low   = l;
    cmd_valid = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_chan = 2'd0; cmd_count = '0; cmd_high = '0; cmd_low = '0;
    stop = 4'h0;
    w_cmd_valid = 1'b0; w_cmd_chan = 2'd0; w_cmd_count = '0; w_cmd_high = '0; w_cmd_low = '0;
    w_stop = 4'h0;
    step(); step();
    rst = 1'b0;
    step();
    total++; if (fast !== 4'h0) $display("FAIL reset_fast: got %h want 0", fast); else passed++;
    total++; if (busy !== 4'h0) $display("FAIL reset_busy: got %h want 0", busy); else passed++;
    total++; if (done !== 4'h0) $display("FAIL reset_done: got %h want 0", done); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (chan_val(i) !== '0) $display("FAIL reset_channel%0d: got %0h want 0", i, chan_val(i));
      else passed++;
    end
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else passed++;
  endtask

  task automatic test_pulse_train();
    logic exp;
    issue(2'd0, 32'd3, 16'd2, 16'd3);
    total++; if (cmd_ready !== 1'b1) $display("FAIL t1_ready: got %b want 1", cmd_ready); else passed++;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) step();
      exp = (k <= 15) && (((k - 1) % 5) < 2);
      total++;
      if (fast[0] !== exp) $display("FAIL t1_fast0_k%0d: got %b want %b", k, fast[0], exp);
      else passed++;
      if (k == 15) begin
        total++; if (busy[0] !== 1'b1) $display("FAIL t1_busy_k15: got %b want 1", busy[0]); else passed++;
        total++; if (done[0] !== 1'b0) $display("FAIL t1_done_k15: got %b want 0", done[0]); else passed++;
      end
      if (k == 16) begin
        total++; if (done[0] !== 1'b1) $display("FAIL t1_done_k16: got %b want 1", done[0]); else passed++;
        total++; if (busy[0] !== 1'b0) $display("FAIL t1_busy_k16: got %b want 0", busy[0]); else passed++;
        total++; if (channel0 !== 32'd3) $display("FAIL t1_channel0: got %0d want 3", channel0); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL t1_ready_at_done: got %b want 1", cmd_ready); else passed++;
      end
    end
    step();
    total++; if (done[0] !== 1'b0) $display("FAIL t1_done_pulse_width: got %b want 0", done[0]); else passed++;
  endtask

  task automatic test_zero_count();
    issue(2'd2, 32'd0, 16'd5, 16'd5);
    step();
    cmd_valid = 1'b0;
    total++; if (done[2] !== 1'b1) $display("FAIL t2_done: got %b want 1", done[2]); else passed++;
    total++; if (busy[2] !== 1'b0) $display("FAIL t2_busy: got %b want 0", busy[2]); else passed++;
    total++; if (fast[2] !== 1'b0) $display("FAIL t2_fast: got %b want 0", fast[2]); else passed++;
    step();
    total++; if (done[2] !== 1'b0) $display("FAIL t2_done_after: got %b want 0", done[2]); else passed++;
    total++; if (channel2 !== 32'd0) $display("FAIL t2_channel2: got %0d want 0", channel2); else passed++;
  endtask

  task automatic test_min_period();
    logic exp;
    issue(2'd1, 32'd5, 16'd0, 16'd0);
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) step();
      exp = (k <= 10) && ((k % 2) == 1);
      total++;
      if (fast[1] !== exp) $display("FAIL t3_fast1_k%0d: got %b want %b", k, fast[1], exp);
      else passed++;
      if (k == 3) begin
        issue(2'd1, 32'd2, 16'd1, 16'd1);
        total++; if (cmd_ready !== 1'b0) $display("FAIL t3_ready_busy_ch1: got %b want 0", cmd_ready); else passed++;
      end
      if (k == 4) begin
        issue(2'd3, 32'd1, 16'd1, 16'd1);
        total++; if (cmd_ready !== 1'b1) $display("FAIL t3_ready_ch3: got %b want 1", cmd_ready); else passed++;
      end
      if (k == 5) begin
        cmd_valid = 1'b0;
        total++; if (fast[3] !== 1'b1) $display("FAIL t3_fast3_high: got %b want 1", fast[3]); else passed++;
      end
      if (k == 6) begin
        total++; if (fast[3] !== 1'b0) $display("FAIL t3_fast3_low: got %b want 0", fast[3]); else passed++;
      end
      if (k == 7) begin
        total++; if (done[3] !== 1'b1) $display("FAIL t3_done3: got %b want 1", done[3]); else passed++;
        total++; if (channel3 !== 32'd1) $display("FAIL t3_channel3: got %0d want 1", channel3); else passed++;
      end
      if (k == 11) begin
        total++; if (done[1] !== 1'b1) $display("FAIL t3_done1: got %b want 1", done[1]); else passed++;
        total++; if (busy[1] !== 1'b0) $display("FAIL t3_busy1: got %b want 0", busy[1]); else passed++;
        total++; if (channel1 !== 32'd5) $display("FAIL t3_channel1: got %0d want 5", channel1); else passed++;
      end
    end
  endtask

  task automatic test_stop();
    logic exp;
    issue(2'd0, 32'd10, 16'd4, 16'd4);
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      if (k > 1) step();
      exp = ((k - 1) % 8) < 4;
      total++;
      if (fast[0] !== exp) $display("FAIL t4_fast0_k%0d: got %b want %b", k, fast[0], exp);
      else passed++;
    end
    stop = 4'b0001;
    step();
    total++; if (fast[0] !== 1'b0) $display("FAIL t4_fast_after_stop: got %b want 0", fast[0]); else passed++;
    total++; if (busy[0] !== 1'b0) $display("FAIL t4_busy_after_stop: got %b want 0", busy[0]); else passed++;
    total++; if (done[0] !== 1'b0) $display("FAIL t4_no_done_stop: got %b want 0", done[0]); else passed++;
    total++; if (channel0 !== 32'd6) $display("FAIL t4_channel0_kept: got %0d want 6", channel0); else passed++;
    issue(2'd0, 32'd1, 16'd1, 16'd1);
    total++; if (cmd_ready !== 1'b0) $display("FAIL t4_ready_stop_idle: got %b want 0", cmd_ready); else passed++;
    step();
    total++; if (busy[0] !== 1'b0) $display("FAIL t4_stop_wins: got %b want 0", busy[0]); else passed++;
    stop = 4'h0;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (done[0] !== 1'b0) $display("FAIL t4_no_done_idle_%0d: got %b want 0", k, done[0]); else passed++;
    end
    issue(2'd0, 32'd1, 16'd1, 16'd1);
    total++; if (cmd_ready !== 1'b1) $display("FAIL t4_ready_after_stop: got %b want 1", cmd_ready); else passed++;
    step();
    cmd_valid = 1'b0;
    total++; if (fast[0] !== 1'b1) $display("FAIL t4_new_cmd_fast: got %b want 1", fast[0]); else passed++;
    step(); step();
    total++; if (done[0] !== 1'b1) $display("FAIL t4_new_cmd_done: got %b want 1", done[0]); else passed++;
    total++; if (channel0 !== 32'd7) $display("FAIL t4_channel0_final: got %0d want 7", channel0); else passed++;
  endtask

  task automatic test_wrap_and_reset();
    w_cmd_chan = 2'd0; w_cmd_count = 3'd7; w_cmd_high = 16'd0; w_cmd_low = 16'd0; w_cmd_valid = 1'b1;
    step();
    w_cmd_valid = 1'b0;
    for (int k = 0; k < 30 && !w_done[0]; k++) step();
    total++; if (w_done[0] !== 1'b1) $display("FAIL t5_wrap_done1: got %b want 1", w_done[0]); else passed++;
    total++; if (w_ch0 !== 3'd7) $display("FAIL t5_wrap_max: got %0d want 7", w_ch0); else passed++;
    w_cmd_count = 3'd2; w_cmd_valid = 1'b1;
    step();
    w_cmd_valid = 1'b0;
    for (int k = 0; k < 30 && !w_done[0]; k++) step();
    total++; if (w_done[0] !== 1'b1) $display("FAIL t5_wrap_done2: got %b want 1", w_done[0]); else passed++;
    total++; if (w_ch0 !== 3'd1) $display("FAIL t5_wrap_value: got %0d want 1", w_ch0); else passed++;

    issue(2'd1, 32'd4, 16'd3, 16'd3);
    step();
    cmd_valid = 1'b0;
    step();
    total++; if (fast[1] !== 1'b1) $display("FAIL t5_midpulse_high: got %b want 1", fast[1]); else passed++;
    rst = 1'b1;
    step();
    total++; if (fast !== 4'h0) $display("FAIL t5_rst_fast: got %h want 0", fast); else passed++;
    total++; if (busy !== 4'h0) $display("FAIL t5_rst_busy: got %h want 0", busy); else passed++;
    total++; if (done !== 4'h0) $display("FAIL t5_rst_done: got %h want 0", done); else passed++;
    total++; if (channel0 !== '0) $display("FAIL t5_rst_channel0: got %0d want 0", channel0); else passed++;
    total++; if (channel1 !== '0) $display("FAIL t5_rst_channel1: got %0d want 0", channel1); else passed++;
    total++; if (w_ch0 !== '0) $display("FAIL t5_rst_wide_ch0: got %0d want 0", w_ch0); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic monitor_cycle();
    for (int i = 0; i < 4; i++) begin
      if (fast[i] && !prev_fast[i]) mc[i] = mc[i] + 1'b1;
      prev_fast[i] = fast[i];
      if (done[i]) begin
        ndone++;
        total++;
        if (chan_val(i) !== mc[i]) $display("FAIL t6_loopback_ch%0d: got %0d want %0d", i, chan_val(i), mc[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_loopback();
    logic [1:0] ch;
    for (int i = 0; i < 4; i++) mc[i] = '0;
    prev_fast = 4'h0;
    ndone = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      monitor_cycle();
      cmd_valid = 1'b0;
      ch = 2'($urandom_range(3));
      if (!busy[ch] && ($urandom_range(2) == 0)) begin
        cmd_chan  = ch;
        cmd_count = CW'($urandom_range(4));
        cmd_high  = WW'($urandom_range(3));
        cmd_low   = WW'($urandom_range(3));
        cmd_valid = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 300 && (busy != 4'h0 || c < 2); c++) begin
      step();
      monitor_cycle();
    end
    total++; if (busy !== 4'h0) $display("FAIL t6_drain: got busy %h want 0", busy); else passed++;
    total++; if (ndone < 4) $display("FAIL t6_done_count: got %0d want at least 4", ndone); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (chan_val(i) !== mc[i]) $display("FAIL t6_final_ch%0d: got %0d want %0d", i, chan_val(i), mc[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_pulse_train();
    test_zero_count();
    test_min_period();
    test_stop();
    test_wrap_and_reset();
    test_loopback();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
